vscale_md_arbiter: RTL and testbench

VSCALE_MD_ARBITER -- requirements
Module: vscale_md_arbiter

---
 rtl/vscale_md_arbiter_if.sv | 29 ++
 rtl/vscale_md_arbiter.sv | 109 ++++++++++
 tb/tb_vscale_md_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_md_arbiter_if.sv
// Command/response channel to or from a shared mul/div unit.
// master issues commands and takes results; slave accepts commands and returns results.
interface vscale_md_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_in_1_signed;
  logic            req_in_2_signed;
  logic            req_op;
  logic            req_out_sel;
  logic [XLEN-1:0] req_in_1;
  logic [XLEN-1:0] req_in_2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;

  modport master (
    output req_valid, req_in_1_signed, req_in_2_signed, req_op, req_out_sel,
           req_in_1, req_in_2, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_in_1_signed, req_in_2_signed, req_op, req_out_sel,
           req_in_1, req_in_2, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/vscale_md_arbiter.sv
// Two-requester arbiter in front of one shared mul/div unit, one command in flight.
// Define MD_ARB_RR_EN for round-robin on ties; otherwise requester 0 has fixed priority.
module vscale_md_arbiter #(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  reset,
  vscale_md_arbiter_if.slave   req0,
  vscale_md_arbiter_if.slave   req1,
  vscale_md_arbiter_if.master  md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  logic            owner;
  logic            last_grant;
  logic [XLEN-1:0] result;
  logic            resp0_valid_q;
  logic            resp1_valid_q;

  logic            any_valid;
  logic            sel;
  logic            offer;
  logic            grant;
  logic            owner_ready;

  always_comb begin
    any_valid = req0.req_valid | req1.req_valid;
`ifdef MD_ARB_RR_EN
    if (req0.req_valid && req1.req_valid) begin
      sel = ~last_grant;
    end else begin
      sel = req1.req_valid;
    end
`else
    sel = ~req0.req_valid;
`endif
  end

  // The request is offered only in IDLE and never while reset is held.
  assign offer = (state == IDLE) && any_valid && !reset;
  assign grant = offer && md.req_ready;

  assign md.req_valid       = offer;
  assign md.req_in_1_signed = sel ? req1.req_in_1_signed : req0.req_in_1_signed;
  assign md.req_in_2_signed = sel ? req1.req_in_2_signed : req0.req_in_2_signed;
  assign md.req_op          = sel ? req1.req_op          : req0.req_op;
  assign md.req_out_sel     = sel ? req1.req_out_sel     : req0.req_out_sel;
  assign md.req_in_1        = sel ? req1.req_in_1        : req0.req_in_1;
  assign md.req_in_2        = sel ? req1.req_in_2        : req0.req_in_2;
  assign md.resp_ready      = (state == BUSY);

  assign req0.req_ready = offer && !sel && md.req_ready;
  assign req1.req_ready = offer &&  sel && md.req_ready;

  assign req0.resp_valid  = resp0_valid_q;
  assign req1.resp_valid  = resp1_valid_q;
  assign req0.resp_result = result;
  assign req1.resp_result = result;

  assign owner_ready = owner ? req1.resp_ready : req0.resp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      result        <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner      <= sel;
            last_grant <= sel;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (md.resp_valid) begin
            result        <= md.resp_result;
            resp0_valid_q <= ~owner;
            resp1_valid_q <= owner;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (owner_ready) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          resp0_valid_q <= 1'b0;
          resp1_valid_q <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_md_arbiter.sv
// Self-checking bench for vscale_md_arbiter with a behavioural mul/div unit.
module tb_vscale_md_arbiter;
  localparam int XLEN = 32;

  typedef struct {
    logic        s1;
    logic        s2;
    logic        op;
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } cmd_t;

  typedef struct {
    int          who;
    logic        s1;
    logic        s2;
    logic        op;
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vscale_md_arbiter_if #(.XLEN(XLEN)) r0 ();
  vscale_md_arbiter_if #(.XLEN(XLEN)) r1 ();
  vscale_md_arbiter_if #(.XLEN(XLEN)) md ();

  vscale_md_arbiter #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (r0),
    .req1  (r1),
    .md    (md)
  );

  int checks = 0;
  int errors = 0;

  cmd_t        cq0[$];
  cmd_t        cq1[$];
  logic [31:0] eq0[$];
  logic [31:0] eq1[$];
  int          glog[$];

  logic rr0 = 1'b1;
  logic rr1 = 1'b1;
  logic mready = 1'b1;
  logic stray = 1'b0;
  int   unit_lat = 2;

  logic        rdy_s0 = 1'b0;
  logic        rdy_s1 = 1'b0;
  logic        g_s = 1'b0;
  logic [31:0] cap_res = '0;
  logic        busy = 1'b0;
  logic        genuine = 1'b0;
  int          cnt = 0;
  logic [31:0] mres = '0;

  assign r0.resp_ready = rr0;
  assign r1.resp_ready = rr1;
  assign md.req_ready  = mready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic cmd_t mk(input logic s1, input logic s2, input logic op, input logic sel,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    cmd_t c;
    c.s1 = s1; c.s2 = s2; c.op = op; c.sel = sel; c.a = a; c.b = b; c.exp = exp;
    return c;
  endfunction

  function automatic logic [31:0] unit_fn(input logic s1, input logic s2, input logic op,
                                          input logic sel, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] x;
    logic signed [32:0] y;
    logic signed [65:0] p;
    if (!op) begin
      x = {s1 & a[31], a};
      y = {s2 & b[31], b};
      p = x * y;
      return sel ? p[63:32] : p[31:0];
    end
    if (b == 32'd0) return sel ? a : 32'hFFFF_FFFF;
    return sel ? (a % b) : (a / b);
  endfunction

  // Requester drivers: hold a command until the handshake seen at the previous edge.
  initial begin
    cmd_t c;
    r0.req_valid = 1'b0; r0.req_in_1_signed = 1'b0; r0.req_in_2_signed = 1'b0;
    r0.req_op = 1'b0; r0.req_out_sel = 1'b0; r0.req_in_1 = '0; r0.req_in_2 = '0;
    r1.req_valid = 1'b0; r1.req_in_1_signed = 1'b0; r1.req_in_2_signed = 1'b0;
    r1.req_op = 1'b0; r1.req_out_sel = 1'b0; r1.req_in_1 = '0; r1.req_in_2 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (r0.req_valid && rdy_s0) r0.req_valid = 1'b0;
      if (!r0.req_valid && cq0.size() != 0) begin
        c = cq0.pop_front();
        r0.req_in_1_signed = c.s1; r0.req_in_2_signed = c.s2;
        r0.req_op = c.op; r0.req_out_sel = c.sel;
        r0.req_in_1 = c.a; r0.req_in_2 = c.b;
        r0.req_valid = 1'b1;
        eq0.push_back(c.exp);
      end
      if (r1.req_valid && rdy_s1) r1.req_valid = 1'b0;
      if (!r1.req_valid && cq1.size() != 0) begin
        c = cq1.pop_front();
        r1.req_in_1_signed = c.s1; r1.req_in_2_signed = c.s2;
        r1.req_op = c.op; r1.req_out_sel = c.sel;
        r1.req_in_1 = c.a; r1.req_in_2 = c.b;
        r1.req_valid = 1'b1;
        eq1.push_back(c.exp);
      end
    end
  end

  // Mul/div unit model: answers after unit_lat cycles with a one-cycle pulse.
  initial begin
    md.resp_valid  = 1'b0;
    md.resp_result = '0;
    forever begin
      @(posedge clk);
      md.resp_valid <= 1'b0;
      genuine       <= 1'b0;
      if (reset) begin
        busy <= 1'b0;
      end else begin
        if (busy) begin
          if (cnt <= 1) begin
            busy           <= 1'b0;
            md.resp_valid  <= 1'b1;
            md.resp_result <= mres;
            genuine        <= 1'b1;
          end else begin
            cnt <= cnt - 1;
          end
        end else if (stray) begin
          md.resp_valid  <= 1'b1;
          md.resp_result <= 32'hDEAD_BEEF;
        end
        if (g_s) begin
          busy <= 1'b1;
          cnt  <= unit_lat;
          mres <= cap_res;
        end
      end
    end
  end

  // Monitor/scoreboard, sampling on the falling edge.
  initial begin
    logic        exp_rise;
    logic        pv0, pc0, pv1, pc1;
    logic [31:0] pr0, pr1;
    int          gi;
    exp_rise = 1'b0; pv0 = 1'b0; pc0 = 1'b0; pv1 = 1'b0; pc1 = 1'b0; pr0 = '0; pr1 = '0;
    forever begin
      @(negedge clk);
      rdy_s0 = r0.req_ready;
      rdy_s1 = r1.req_ready;
      if (exp_rise) chk("resp_latency", 32'(r0.resp_valid | r1.resp_valid), 32'd1);
      exp_rise = md.resp_valid && genuine && !reset;
      if (exp_rise) chk("resp_early", 32'(r0.resp_valid | r1.resp_valid), 32'd0);

      g_s = md.req_valid && md.req_ready;
      if (g_s) begin
        chk("one_outstanding", 32'(busy), 32'd0);
        chk("grant_onehot", 32'(int'(r0.req_ready) + int'(r1.req_ready)), 32'd1);
        gi = r1.req_ready ? 1 : 0;
        glog.push_back(gi);
        chk("md_in_1", md.req_in_1, gi != 0 ? r1.req_in_1 : r0.req_in_1);
        chk("md_in_2", md.req_in_2, gi != 0 ? r1.req_in_2 : r0.req_in_2);
        chk("md_flags", 32'({md.req_in_1_signed, md.req_in_2_signed, md.req_op, md.req_out_sel}),
            gi != 0 ? 32'({r1.req_in_1_signed, r1.req_in_2_signed, r1.req_op, r1.req_out_sel})
                    : 32'({r0.req_in_1_signed, r0.req_in_2_signed, r0.req_op, r0.req_out_sel}));
        cap_res = unit_fn(md.req_in_1_signed, md.req_in_2_signed, md.req_op, md.req_out_sel,
                          md.req_in_1, md.req_in_2);
      end

      if (r0.resp_valid) begin
        chk("resp_exclusive", 32'(r1.resp_valid), 32'd0);
        if (pv0 && !pc0) chk("resp0_stable", r0.resp_result, pr0);
        if (rr0) begin
          if (eq0.size() == 0) fail("resp0_unexpected");
          else chk("resp0_result", r0.resp_result, eq0.pop_front());
        end
      end
      if (r1.resp_valid) begin
        if (pv1 && !pc1) chk("resp1_stable", r1.resp_result, pr1);
        if (rr1) begin
          if (eq1.size() == 0) fail("resp1_unexpected");
          else chk("resp1_result", r1.resp_result, eq1.pop_front());
        end
      end
      pv0 = r0.resp_valid; pc0 = r0.resp_valid && rr0; pr0 = r0.resp_result;
      pv1 = r1.resp_valid; pc1 = r1.resp_valid && rr1; pr1 = r1.resp_result;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cq0.size() == 0 && cq1.size() == 0 && eq0.size() == 0 && eq1.size() == 0 &&
          !r0.req_valid && !r1.req_valid) return;
    end
    fail("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   gb;
    int   exp_g;
    bit   seen;

    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7,         32'd6,         32'd42,        1};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd2,         32'h0000_0001, 3};
    vecs[2] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 2};
    vecs[3] = '{1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 4};
    vecs[4] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
    vecs[5] = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[6] = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        5};
    vecs[7] = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd100,       32'd7,         32'd2,         1};

    // Both requesters valid while still in reset.
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cq0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'(k + 1), 32'd3, 32'(3 * (k + 1))));
      cq1.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'(k + 10), 32'd2, 32'(2 * (k + 10))));
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_md_valid",    32'(md.req_valid),   32'd0);
      chk("rst_req0_ready",  32'(r0.req_ready),   32'd0);
      chk("rst_req1_ready",  32'(r1.req_ready),   32'd0);
      chk("rst_resp0_valid", 32'(r0.resp_valid),  32'd0);
      chk("rst_resp1_valid", 32'(r1.resp_valid),  32'd0);
    end
    step();
    reset = 1'b0;
    wait_drain(400);
    chk("arb_grant_count", 32'(glog.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
`ifdef MD_ARB_RR_EN
      exp_g = k % 2;
`else
      exp_g = (k < 4) ? 0 : 1;
`endif
      if (k < glog.size()) chk($sformatf("arb_grant_%0d", k), 32'(glog[k]), 32'(exp_g));
    end

    // Single-requester vectors.
    for (int v = 0; v < 8; v++) begin
      step();
      unit_lat = vecs[v].lat;
      gb = glog.size();
      if (vecs[v].who == 0)
        cq0.push_back(mk(vecs[v].s1, vecs[v].s2, vecs[v].op, vecs[v].sel, vecs[v].a, vecs[v].b, vecs[v].exp));
      else
        cq1.push_back(mk(vecs[v].s1, vecs[v].s2, vecs[v].op, vecs[v].sel, vecs[v].a, vecs[v].b, vecs[v].exp));
      wait_drain(100);
      chk($sformatf("vec%0d_grants", v), 32'(glog.size() - gb), 32'd1);
      if (glog.size() > gb) chk($sformatf("vec%0d_grant_idx", v), 32'(glog[gb]), 32'(vecs[v].who));
    end

    // Unit back-pressure: request offered but not accepted.
    step();
    mready = 1'b0;
    gb = glog.size();
    cq0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd81));
    repeat (2) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("bp_md_valid",   32'(md.req_valid), 32'd1);
      chk("bp_req0_ready", 32'(r0.req_ready), 32'd0);
    end
    chk("bp_no_grant", 32'(glog.size() - gb), 32'd0);
    step();
    mready = 1'b1;
    wait_drain(100);

    // Result held in HOLD while requester 0 stalls and requester 1 waits.
    step();
    unit_lat = 1;
    rr0 = 1'b0;
    gb = glog.size();
    cq0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780));
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (r0.resp_valid) seen = 1'b1;
    end
    if (!seen) fail("hold_wait_timeout");
    step();
    cq1.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h10, 32'h0000_0001));
    repeat (10) begin
      @(negedge clk);
      chk("hold_resp0_valid", 32'(r0.resp_valid), 32'd1);
      chk("hold_resp1_valid", 32'(r1.resp_valid), 32'd0);
      chk("hold_req1_ready",  32'(r1.req_ready),  32'd0);
      chk("hold_md_valid",    32'(md.req_valid),  32'd0);
    end
    step();
    rr0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_next_grant_req1", 32'(r1.req_ready), 32'd1);
    wait_drain(100);
    chk("hold_grant_count", 32'(glog.size() - gb), 32'd2);
    if (glog.size() >= gb + 2) chk("hold_second_grant", 32'(glog[gb + 1]), 32'd1);

    // Reset while the unit is busy: the result must be dropped.
    step();
    unit_lat = 10;
    gb = glog.size();
    cq0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd11, 32'd11, 32'd121));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (glog.size() > gb) seen = 1'b1;
    end
    if (!seen) fail("busy_wait_timeout");
    repeat (2) @(negedge clk);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    eq0.delete();
    repeat (14) begin
      @(negedge clk);
      chk("rst_busy_resp0", 32'(r0.resp_valid), 32'd0);
      chk("rst_busy_resp1", 32'(r1.resp_valid), 32'd0);
    end
    step();
    unit_lat = 2;
    cq1.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780));
    wait_drain(100);

    // Stray unit response while idle must be ignored.
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stray_resp0", 32'(r0.resp_valid), 32'd0);
      chk("stray_resp1", 32'(r1.resp_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
